fpga_tg_sequencer: RTL and testbench
====================================

# fpga_tg_sequencer

Hardware launcher for the traffic generators inside `fpga_picobello_top`. It drives the narrow AXI host port with single-beat writes, replacing bench-driven host stimulus on the FPGA build. It writes a configuration word to every traffic generator, then writes a launch command to every generator. It then waits until all generators have reported busy and gone idle again, or until a timeout expires. Status is exposed to a debug/VIO interface.

## Interface
Parameters:
- `NumTrafficGenerators`, default `picobello_pkg::NumClusters + 1`: number of generators sequenced.
- `TgBaseAddr`, default `64'h0000_0000_1000_0000`: register window of generator 0.
- `TgStride`, default `64'h0000_0000_0000_1000`: address distance between generator windows.
- `CfgOffset`, default `64'h0`: configuration register offset.
- `LaunchOffset`, default `64'h8`: launch register offset.
- `TimeoutCycles`, default `1_000_000`: maximum number of cycles spent in WAIT, counted in a 32-bit counter.
- `axi_req_t`, default `floo_picobello_noc_pkg::axi_narrow_in_req_t`: request struct type.
- `axi_rsp_t`, default `floo_picobello_noc_pkg::axi_narrow_in_rsp_t`: response struct type.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, synchronous, active-low.
- `start_i`, in, 1: start pulse; sampled only in IDLE or DONE.
- `cfg_word_i`, in, DataWidth: configuration value written to every generator; sampled at start.
- `tg_busy_i`, in, NumTrafficGenerators: per-generator busy flags.
- `axi_req_o`, out, `axi_req_t`: host AXI request.
- `axi_rsp_i`, in, `axi_rsp_t`: host AXI response.
- `busy_o`, out, 1: sequence in progress.
- `done_o`, out, 1: sequence finished. Holds until the next start or reset.
- `err_o`, out, 1: a write returned a response other than `RESP_OKAY`.
- `timeout_o`, out, 1: WAIT expired before all generators finished.
- `err_idx_o`, out, max(1,$clog2(NumTrafficGenerators)): index of the generator whose write failed.

## Operation
- Reset values: all outputs 0; all AXI valid and ready fields 0; state IDLE.
- Each sequence is a list of 2N single-beat writes:
  - Step i < N: address `TgBaseAddr + i*TgStride + CfgOffset`, data `cfg_word_i` (registered).
  - Step N+i: address `TgBaseAddr + i*TgStride + LaunchOffset`, data `64'h1`.
- Fixed AXI fields on every write:
  - `id`, `len`, `lock`, `cache`, `prot`, `qos`, `region`, `atop`, `user` = 0.
  - `size` = $clog2(DataWidth/8); `burst` = `BURST_INCR`.
  - `strb` = all ones; `last` = 1.
- The read channels are never used: `ar_valid` = 0 and `r_ready` = 0 at all times.
- States:
  - IDLE: on `start_i`, clear all status flags, `step` = 0, `seen` = 0; go to AW.
  - AW: `aw_valid` = 1 with the step's address. On `aw_ready`, go to W.
  - W: `w_valid` = 1. On `w_ready`, go to B.
  - B: `b_ready` = 1. On `b_valid`:
    - If resp ≠ OKAY: set `err_o`, set `err_idx_o` = step mod N, go to DONE.
    - Else if step = 2N-1: go to WAIT with the cycle counter at 0.
    - Else: increment step and go to AW.
  - WAIT:
    - Every cycle, `seen |= tg_busy_i`.
    - When `seen` is all ones and `tg_busy_i` is all zeros, go to DONE.
    - If the counter reaches `TimeoutCycles-1`, set `timeout_o` and go to DONE. Otherwise the counter increments each cycle.
  - DONE: `done_o` = 1. On `start_i`, restart exactly as from IDLE.
- `busy_o` is 1 in the AW, W, B and WAIT states.
- AW/W payload stability: address and data stay stable while valid is high and not yet accepted; valid never drops before its handshake completes.
- AW and W are never overlapped. At most one write is outstanding.
- A `start_i` pulse arriving in AW, W, B or WAIT is ignored.
- Address arithmetic is 64-bit and wraps modulo 2^64 without a flag.

## Timing
- With `start_i` high at edge k, `aw_valid` is high in cycle k+1.
- Against a slave that is always ready and returns B in the cycle after W: each write takes 3 cycles (AW, W, B). The write phase therefore takes 6N cycles.
- When the busy exit condition holds at edge t, `done_o` rises in cycle t+1.
- A timeout sets `done_o` and `timeout_o` in the same cycle.
- A `start_i` pulse in DONE clears `done_o` in the next cycle.
- If `aw_ready` is already high in the first AW cycle, the handshake completes in that same cycle (zero added wait).
- Reset asserted mid-transaction forces IDLE at the next edge and drops all valids. A downstream AXI reset must accompany it.
- A busy pulse one cycle long counts as `seen`.

## Test plan
- Bench setup: N=2 with an always-ready OKAY slave. Send `start_i` with `cfg_word_i`=`64'hA5`.
  - Required writes, in order: `0x1000_0000`←A5, `0x1000_1000`←A5, `0x1000_0008`←1, `0x1000_1008`←1. Each write takes 3 cycles.
  - Then raise `tg_busy_i`=`2'b11` for 10 cycles and drop it. `done_o` rises one cycle after the drop; `err_o`=0 and `timeout_o`=0.
- Backpressure: hold `aw_ready` low for 5 cycles, then `w_ready` low for 3 cycles. Address and data stay stable throughout, and the sequence is unchanged.
- Error: return `SLVERR` on write 3 (the launch of TG0). Required: DONE with `err_o`=1 and `err_idx_o`=0; no fourth write is issued.
- Timeout: `TimeoutCycles`=100, and TG1 never raises busy. Required: `timeout_o`=1 and `done_o`=1 exactly 100 cycles after entering WAIT.
- Reset: drop `rst_ni` while in W. Required: `w_valid`=0 and all outputs 0 at the next edge. A new `start_i` then restarts from write 0.
- Restart from DONE: a second `start_i` with `cfg_word_i`=`64'h5A` clears the flags and reruns the full sequence with the new data.

Source files
------------

// File: rtl/fpga_tg_sequencer.sv
// Traffic-generator launcher: writes a config word and then a launch command to every
// generator over the narrow AXI host port, then waits for all of them to finish or time out.

package fpga_tg_sequencer_pkg;

    localparam int unsigned NumClusters = 16;
    localparam int unsigned DataWidth   = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } axi_narrow_aw_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [0:0]  user;
    } axi_narrow_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } axi_narrow_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } axi_narrow_ar_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } axi_narrow_r_t;

    typedef struct packed {
        axi_narrow_aw_t aw;
        logic           aw_valid;
        axi_narrow_w_t  w;
        logic           w_valid;
        logic           b_ready;
        axi_narrow_ar_t ar;
        logic           ar_valid;
        logic           r_ready;
    } axi_narrow_in_req_t;

    typedef struct packed {
        logic          aw_ready;
        logic          ar_ready;
        logic          w_ready;
        logic          b_valid;
        axi_narrow_b_t b;
        logic          r_valid;
        axi_narrow_r_t r;
    } axi_narrow_in_rsp_t;

endpackage

module fpga_tg_sequencer #(
    parameter int unsigned NumTrafficGenerators = fpga_tg_sequencer_pkg::NumClusters + 1,
    parameter int unsigned DataWidth            = fpga_tg_sequencer_pkg::DataWidth,
    parameter logic [63:0] TgBaseAddr           = 64'h0000_0000_1000_0000,
    parameter logic [63:0] TgStride             = 64'h0000_0000_0000_1000,
    parameter logic [63:0] CfgOffset            = 64'h0,
    parameter logic [63:0] LaunchOffset         = 64'h8,
    parameter int unsigned TimeoutCycles        = 32'd1_000_000,
    parameter type axi_req_t = fpga_tg_sequencer_pkg::axi_narrow_in_req_t,
    parameter type axi_rsp_t = fpga_tg_sequencer_pkg::axi_narrow_in_rsp_t,
    localparam int unsigned IdxW = (NumTrafficGenerators > 1) ? $clog2(NumTrafficGenerators) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic [DataWidth-1:0]            cfg_word_i,
    input  logic [NumTrafficGenerators-1:0] tg_busy_i,
    output axi_req_t                        axi_req_o,
    input  axi_rsp_t                        axi_rsp_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o,
    output logic                            timeout_o,
    output logic [IdxW-1:0]                 err_idx_o
);

    import fpga_tg_sequencer_pkg::RESP_OKAY;
    import fpga_tg_sequencer_pkg::BURST_INCR;

    localparam int unsigned NumSteps    = 2 * NumTrafficGenerators;
    localparam int unsigned StepW       = $clog2(NumSteps);
    localparam logic [StepW-1:0] NumTg  = StepW'(NumTrafficGenerators);
    localparam logic [StepW-1:0] LastStep = StepW'(NumSteps - 1);
    localparam logic [31:0] TimeoutLast = 32'(TimeoutCycles - 1);
    localparam logic [2:0]  AxSize      = 3'($clog2(DataWidth / 8));

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_WAIT = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    state_e                          state_r;
    logic [StepW-1:0]                step_r;
    logic [NumTrafficGenerators-1:0] seen_r;
    logic [31:0]                     cnt_r;
    logic [DataWidth-1:0]            cfg_r;
    logic [DataWidth-1:0]            data_r;
    logic [63:0]                     addr_r;
    logic                            aw_valid_r;
    logic                            w_valid_r;
    logic                            b_ready_r;
    logic                            busy_r;
    logic                            done_r;
    logic                            err_r;
    logic                            timeout_r;
    logic [IdxW-1:0]                 err_idx_r;
    logic                            rsp_unused_s;

    // Steps 0..N-1 target the config registers, steps N..2N-1 the launch registers.
    function automatic logic [IdxW-1:0] step_to_idx(input logic [StepW-1:0] step);
        if (step >= NumTg) begin
            return IdxW'(step - NumTg);
        end else begin
            return IdxW'(step);
        end
    endfunction

    function automatic logic [63:0] tg_addr(input logic [StepW-1:0] step);
        logic [63:0] idx_s;
        logic [63:0] off_s;
        idx_s = 64'(step_to_idx(step));
        off_s = (step >= NumTg) ? LaunchOffset : CfgOffset;
        return TgBaseAddr + idx_s * TgStride + off_s;
    endfunction

    // Sequencer FSM with all handshake and status outputs registered.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            step_r     <= '0;
            seen_r     <= '0;
            cnt_r      <= 32'd0;
            cfg_r      <= '0;
            data_r     <= '0;
            addr_r     <= 64'd0;
            aw_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
            b_ready_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            timeout_r  <= 1'b0;
            err_idx_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_r    <= ST_AW;
                        step_r     <= '0;
                        seen_r     <= '0;
                        cnt_r      <= 32'd0;
                        cfg_r      <= cfg_word_i;
                        addr_r     <= tg_addr('0);
                        aw_valid_r <= 1'b1;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        err_r      <= 1'b0;
                        timeout_r  <= 1'b0;
                        err_idx_r  <= '0;
                    end
                end
                ST_AW: begin
                    if (axi_rsp_i.aw_ready) begin
                        aw_valid_r <= 1'b0;
                        w_valid_r  <= 1'b1;
                        data_r     <= (step_r >= NumTg) ? DataWidth'(64'h1) : cfg_r;
                        state_r    <= ST_W;
                    end
                end
                ST_W: begin
                    if (axi_rsp_i.w_ready) begin
                        w_valid_r <= 1'b0;
                        b_ready_r <= 1'b1;
                        state_r   <= ST_B;
                    end
                end
                ST_B: begin
                    if (axi_rsp_i.b_valid) begin
                        b_ready_r <= 1'b0;
                        if (axi_rsp_i.b.resp != RESP_OKAY) begin
                            err_r     <= 1'b1;
                            err_idx_r <= step_to_idx(step_r);
                            done_r    <= 1'b1;
                            busy_r    <= 1'b0;
                            state_r   <= ST_DONE;
                        end else if (step_r == LastStep) begin
                            cnt_r   <= 32'd0;
                            state_r <= ST_WAIT;
                        end else begin
                            step_r     <= step_r + StepW'(1);
                            addr_r     <= tg_addr(step_r + StepW'(1));
                            aw_valid_r <= 1'b1;
                            state_r    <= ST_AW;
                        end
                    end
                end
                ST_WAIT: begin
                    seen_r <= seen_r | tg_busy_i;
                    // Every generator must have been seen busy before idle counts as finished.
                    if ((&seen_r) && !(|tg_busy_i)) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else if (cnt_r == TimeoutLast) begin
                        timeout_r <= 1'b1;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    aw_valid_r <= 1'b0;
                    w_valid_r  <= 1'b0;
                    b_ready_r  <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Drive the host request: single-beat INCR writes, read channels idle.
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.addr  = addr_r;
        axi_req_o.aw.size  = AxSize;
        axi_req_o.aw.burst = BURST_INCR;
        axi_req_o.aw_valid = aw_valid_r;
        axi_req_o.w.data   = data_r;
        axi_req_o.w.strb   = '1;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = w_valid_r;
        axi_req_o.b_ready  = b_ready_r;
    end

    assign rsp_unused_s = ^axi_rsp_i;

    assign busy_o    = busy_r;
    assign done_o    = done_r;
    assign err_o     = err_r;
    assign timeout_o = timeout_r;
    assign err_idx_o = err_idx_r;

endmodule

// File: tb/tb_fpga_tg_sequencer.sv
// Directed bench for fpga_tg_sequencer with two generators and a small AXI write slave model.

module tb_fpga_tg_sequencer;

    import fpga_tg_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] cfg_word = 64'd0;
    logic [1:0]  tg_busy = 2'b00;
    axi_narrow_in_req_t axi_req;
    axi_narrow_in_rsp_t axi_rsp;
    logic        busy, done, err, timeout;
    logic [0:0]  err_idx;

    int n_vec = 0;
    int n_miss = 0;

    int cyc = 0;
    int aw_stall = 0;
    int w_stall = 0;
    int err_at = -1;
    int aw_wait = 0;
    int w_wait = 0;
    logic b_pend = 1'b0;
    logic [1:0] b_resp = 2'b00;
    int aw_n = 0;
    int w_n = 0;
    int b_n = 0;
    logic [63:0] aw_addr_log [64];
    logic [63:0] w_data_log [64];
    int          aw_cyc_log [64];

    logic        stab_bad = 1'b0;
    logic        aw_pend_prev = 1'b0;
    logic        w_pend_prev = 1'b0;
    logic [63:0] aw_addr_prev = 64'd0;
    logic [63:0] w_data_prev = 64'd0;

    int k_start = 0;
    logic [63:0] exp_addr [4];

    fpga_tg_sequencer #(
        .NumTrafficGenerators(2),
        .TimeoutCycles(100)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .start_i(start),
        .cfg_word_i(cfg_word),
        .tg_busy_i(tg_busy),
        .axi_req_o(axi_req),
        .axi_rsp_i(axi_rsp),
        .busy_o(busy),
        .done_o(done),
        .err_o(err),
        .timeout_o(timeout),
        .err_idx_o(err_idx)
    );

    always #5 clk = ~clk;

    // Slave response: ready after a programmable number of stall cycles, B one cycle after W.
    always_comb begin
        axi_rsp          = '0;
        axi_rsp.aw_ready = (aw_wait >= aw_stall);
        axi_rsp.w_ready  = (w_wait >= w_stall);
        axi_rsp.b_valid  = b_pend;
        axi_rsp.b.resp   = b_resp;
    end

    // Slave state and write log.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            aw_wait <= 0;
            w_wait  <= 0;
            b_pend  <= 1'b0;
        end else begin
            if (axi_req.aw_valid) begin
                if (axi_rsp.aw_ready) begin
                    aw_addr_log[aw_n] <= axi_req.aw.addr;
                    aw_cyc_log[aw_n]  <= cyc;
                    aw_n    <= aw_n + 1;
                    aw_wait <= 0;
                end else begin
                    aw_wait <= aw_wait + 1;
                end
            end
            if (b_pend && axi_req.b_ready) begin
                b_pend <= 1'b0;
                b_n    <= b_n + 1;
            end
            if (axi_req.w_valid) begin
                if (axi_rsp.w_ready) begin
                    w_data_log[w_n] <= axi_req.w.data;
                    w_n    <= w_n + 1;
                    w_wait <= 0;
                    b_pend <= 1'b1;
                    b_resp <= (w_n == err_at) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    w_wait <= w_wait + 1;
                end
            end
        end
    end

    // Payload-stability monitor: a pending valid must persist with the same payload.
    always @(negedge clk) begin
        if (rst_n) begin
            if (aw_pend_prev && !(axi_req.aw_valid && axi_req.aw.addr == aw_addr_prev))
                stab_bad <= 1'b1;
            if (w_pend_prev && !(axi_req.w_valid && axi_req.w.data == w_data_prev))
                stab_bad <= 1'b1;
        end
        aw_pend_prev <= rst_n && axi_req.aw_valid && !axi_rsp.aw_ready;
        w_pend_prev  <= rst_n && axi_req.w_valid && !axi_rsp.w_ready;
        aw_addr_prev <= axi_req.aw.addr;
        w_data_prev  <= axi_req.w.data;
    end

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [63:0] word);
        cfg_word = word;
        start    = 1'b1;
        k_start  = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_b(input int target, input string tag);
        for (int i = 0; i < 400 && b_n < target; i++) @(negedge clk);
        check_vec(tag, 64'(b_n), 64'(target));
    endtask

    task automatic check_writes(input int aw_base, input int w_base, input logic [63:0] cfg,
                                input string tag);
        for (int i = 0; i < 4; i++) begin
            check_vec($sformatf("%s_addr%0d", tag, i), aw_addr_log[aw_base + i], exp_addr[i]);
            check_vec($sformatf("%s_data%0d", tag, i), w_data_log[w_base + i],
                      (i < 2) ? cfg : 64'h1);
        end
    endtask

    task automatic finish_busy(input string tag);
        tg_busy = 2'b11;
        tick(10);
        check_vec({tag, "_pre_done"}, {63'd0, done}, 64'd0);
        tg_busy = 2'b00;
        @(negedge clk);
        check_vec({tag, "_status"}, {60'd0, done, busy, err, timeout}, {60'd0, 4'b1000});
    endtask

    function automatic logic [63:0] out_vec();
        return {54'd0, busy, done, err, timeout, err_idx, axi_req.aw_valid, axi_req.w_valid,
                axi_req.b_ready, axi_req.ar_valid, axi_req.r_ready};
    endfunction

    initial begin
        int aw_base;
        int w_base;
        int b_base;
        int wc;

        exp_addr[0] = 64'h1000_0000;
        exp_addr[1] = 64'h1000_1000;
        exp_addr[2] = 64'h1000_0008;
        exp_addr[3] = 64'h1000_1008;

        // Reset state
        tick(3);
        check_vec("reset_outs", out_vec(), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // Nominal sequence with A5
        aw_base = aw_n; w_base = w_n; b_base = b_n;
        pulse_start(64'hA5);
        check_vec("aw_valid_k1", {63'd0, axi_req.aw_valid}, 64'd1);
        check_vec("aw_fields", {axi_req.aw.size, axi_req.aw.burst, axi_req.aw.len},
                  {51'd0, 3'd3, 2'b01, 8'd0});
        wait_b(b_base + 4, "nom_writes");
        check_writes(aw_base, w_base, 64'hA5, "nom");
        check_vec("nom_t0", 64'(aw_cyc_log[aw_base]), 64'(k_start + 1));
        for (int i = 1; i < 4; i++)
            check_vec($sformatf("nom_dt%0d", i),
                      64'(aw_cyc_log[aw_base + i] - aw_cyc_log[aw_base + i - 1]), 64'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick(2);
        check_vec("start_ignored", {62'd0, busy, axi_req.aw_valid}, 64'b10);
        check_vec("start_ignored_n", 64'(aw_n), 64'(aw_base + 4));
        finish_busy("nom");

        // Restart from DONE with 5A
        aw_base = aw_n; w_base = w_n; b_base = b_n;
        pulse_start(64'h5A);
        check_vec("restart_clr", {62'd0, done, busy}, 64'b01);
        wait_b(b_base + 4, "rst_writes");
        check_writes(aw_base, w_base, 64'h5A, "rerun");
        finish_busy("rerun");

        // Backpressure on AW and W
        aw_stall = 5; w_stall = 3;
        aw_base = aw_n; w_base = w_n; b_base = b_n;
        pulse_start(64'hA5);
        wait_b(b_base + 4, "bp_writes");
        aw_stall = 0; w_stall = 0;
        check_writes(aw_base, w_base, 64'hA5, "bp");
        check_vec("bp_dt", 64'(aw_cyc_log[aw_base + 1] - aw_cyc_log[aw_base]), 64'd11);
        check_vec("bp_stable", {63'd0, stab_bad}, 64'd0);
        finish_busy("bp");

        // SLVERR on the launch of TG0
        aw_base = aw_n; w_base = w_n;
        err_at = w_n + 2;
        pulse_start(64'hA5);
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        tick(5);
        err_at = -1;
        check_vec("err_status", {59'd0, done, busy, err, timeout, err_idx}, {59'd0, 5'b10100});
        check_vec("err_no_4th", 64'(aw_n), 64'(aw_base + 3));

        // Timeout: TG1 never busy
        b_base = b_n;
        pulse_start(64'h77);
        wait_b(b_base + 4, "to_writes");
        wc = 1;
        tg_busy = 2'b01;
        while (!done && wc < 300) begin
            @(negedge clk);
            wc++;
            if (wc == 3) tg_busy = 2'b00;
        end
        check_vec("to_cycles", 64'(wc - 1), 64'd100);
        check_vec("to_status", {60'd0, done, busy, err, timeout}, {60'd0, 4'b1001});

        // Reset asserted in W, then restart from write 0
        pulse_start(64'hA5);
        for (int i = 0; i < 20 && !axi_req.w_valid; i++) @(negedge clk);
        check_vec("in_w", {63'd0, axi_req.w_valid}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_vec("midrst_outs", out_vec(), 64'd0);
        rst_n = 1'b1;
        tick(1);
        aw_base = aw_n; w_base = w_n; b_base = b_n;
        pulse_start(64'h3C);
        wait_b(b_base + 4, "post_rst_writes");
        check_writes(aw_base, w_base, 64'h3C, "post_rst");
        tg_busy = 2'b10;
        tick(1);
        tg_busy = 2'b01;
        tick(1);
        tg_busy = 2'b00;
        tick(1);
        check_vec("pulse_done", {60'd0, done, busy, err, timeout}, {60'd0, 4'b1000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
